// File: rtl/parker_feeder.sv
// Packs six stream words into operand registers, runs the core handshake, returns ap_return on a valid/ready port.
// Latency: 3 cycles from the final accepted word to m_valid (the core raises done 2 cycles after start).
// Backpressure: s_ready is low in RUN and OUT; m_valid holds m_data until m_ready. Optional PARKER_FEEDER_TIMEOUT_EN aborts a stuck RUN.
module parker_feeder #(
    parameter int DATA_W      = 32,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic [DATA_W-1:0] core_in1,
    output logic [DATA_W-1:0] core_in2,
    output logic [DATA_W-1:0] core_in3,
    output logic [DATA_W-1:0] core_in4,
    output logic [DATA_W-1:0] core_in5,
    output logic [DATA_W-1:0] core_in6,
    output logic              core_start,
    input  logic              core_done,
    input  logic              core_ready,
    input  logic [DATA_W-1:0] core_return,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              frame_err,
    output logic              busy,
    output logic [CNT_W-1:0]  done_cnt
);

    typedef enum logic [1:0] {COLLECT = 2'd0, RUN = 2'd1, OUT = 2'd2} state_t;

    state_t            state, state_nxt;
    logic [2:0]        idx;
    logic [DATA_W-1:0] ops [6];
    logic              accept;
    logic              frame_ok;
    logic              frame_bad;
    logic              timeout_hit;

    // core_ready is an observation-only signal from the core
    logic unused_core_ready;
    assign unused_core_ready = core_ready;

    assign accept    = s_valid && s_ready;
    assign frame_ok  = accept && s_last && (idx == 3'd5);
    assign frame_bad = accept && (s_last != (idx == 3'd5));

`ifdef PARKER_FEEDER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt;

    // Zero outside RUN, so it is already clear on the first RUN cycle
    always_ff @(posedge ap_clk) begin
        if (ap_rst || state != RUN) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign timeout_hit = (state == RUN) && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
    assign timeout_hit        = 1'b0;
`endif

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (frame_ok) state_nxt = RUN;
            RUN:     if (core_done || timeout_hit) state_nxt = OUT;
            OUT:     if (m_ready) state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    always_comb begin
        s_ready    = (state == COLLECT);
        core_start = (state == RUN);
        m_valid    = (state == OUT);
        busy       = (state != COLLECT);
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            idx <= '0;
            for (int k = 0; k < 6; k++) ops[k] <= '0;
        end else if (accept) begin
            for (int k = 0; k < 6; k++) begin
                if (idx == 3'(k)) ops[k] <= s_data;
            end
            idx <= (s_last || idx == 3'd5) ? 3'd0 : idx + 3'd1;
        end
    end

    // A done in the same cycle as the timeout wins: normal capture, no error
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            m_data    <= '0;
            frame_err <= 1'b0;
            done_cnt  <= '0;
        end else begin
            frame_err <= frame_bad || (timeout_hit && !core_done);
            if (state == RUN && core_done) begin
                m_data <= core_return;
            end else if (timeout_hit) begin
                m_data <= '0;
            end
            if (state == OUT && m_ready) begin
                done_cnt <= done_cnt + 1'b1;
            end
        end
    end

    assign core_in1 = ops[0];
    assign core_in2 = ops[1];
    assign core_in3 = ops[2];
    assign core_in4 = ops[3];
    assign core_in5 = ops[4];
    assign core_in6 = ops[5];

endmodule

// File: tb/tb_parker_feeder.sv
// Directed bench for parker_feeder with a three-state core model and a result scoreboard.
module tb_parker_feeder;

    localparam int DATA_W      = 32;
    localparam int CNT_W       = 4;
    localparam int TIMEOUT_CYC = 8;

    logic              ap_clk = 1'b0;
    logic              ap_rst;
    logic [DATA_W-1:0] s_data;
    logic              s_valid, s_last, s_ready;
    logic [DATA_W-1:0] core_in1, core_in2, core_in3, core_in4, core_in5, core_in6;
    logic              core_start, core_done, core_ready;
    logic [DATA_W-1:0] core_return;
    logic [DATA_W-1:0] m_data;
    logic              m_valid, m_ready, frame_err, busy;
    logic [CNT_W-1:0]  done_cnt;

    int                checks = 0;
    int                errors = 0;
    int                exp_cnt = 0;
    logic [31:0]       exp_q[$];
    logic [31:0]       last_res = 32'h0;
    logic [31:0]       cin [6];
    logic [1:0]        core_cyc;
    logic              done_en, extra_done, ret_ovr;

    always #5 ap_clk = ~ap_clk;

    parker_feeder #(.DATA_W(DATA_W), .CNT_W(CNT_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .core_in1(core_in1), .core_in2(core_in2), .core_in3(core_in3),
        .core_in4(core_in4), .core_in5(core_in5), .core_in6(core_in6),
        .core_start(core_start), .core_done(core_done), .core_ready(core_ready),
        .core_return(core_return),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .frame_err(frame_err), .busy(busy), .done_cnt(done_cnt)
    );

    assign cin[0] = core_in1;
    assign cin[1] = core_in2;
    assign cin[2] = core_in3;
    assign cin[3] = core_in4;
    assign cin[4] = core_in5;
    assign cin[5] = core_in6;

    // Core model: done in the third cycle of start, result derived from its operands
    always @(posedge ap_clk) begin
        if (ap_rst || !core_start) core_cyc <= 2'd0;
        else if (core_cyc != 2'd3) core_cyc <= core_cyc + 2'd1;
    end
    assign core_done   = (core_start && done_en && core_cyc == 2'd2) || extra_done;
    assign core_ready  = core_done;
    assign core_return = ret_ovr ? 32'h55AA55AA
                       : 32'hDEADBEEF + (core_in1 + core_in2 + core_in3 + core_in4 + core_in5 + core_in6) - 32'd21;

    function automatic logic [31:0] exp_ret(input logic [31:0] base);
        return 32'hDEADBEEF + 32'd6 * base + 32'd15 - 32'd21;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_words(input logic [31:0] base, input int n, input logic last_final);
        for (int k = 0; k < n; k++) begin
            s_data  = base + 32'(k);
            s_valid = 1'b1;
            s_last  = (k == n - 1) && last_final;
            @(negedge ap_clk);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!m_valid && lat < 200) begin
            @(negedge ap_clk);
            lat++;
        end
    endtask

    task automatic collect();
        logic [31:0] exp;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hBAD0BAD0;
        m_ready = 1'b1;
        check("m_data", m_data, exp);
        last_res = exp;
        @(negedge ap_clk);
        m_ready = 1'b0;
        exp_cnt++;
        check("m_valid_after_accept", m_valid, 0);
        check("busy_after_accept", busy, 0);
        check("done_cnt", done_cnt, 32'(exp_cnt % (1 << CNT_W)));
    endtask

    task automatic run_frame(input logic [31:0] base, input int hold);
        int lat;
        send_words(base, 6, 1'b1);
        exp_q.push_back(exp_ret(base));
        check("core_start_run", core_start, 1);
        check("s_ready_run", s_ready, 0);
        for (int k = 0; k < 6; k++) check("core_in", cin[k], base + 32'(k));
        wait_valid(lat);
        check("latency", 32'(lat), 3);
        for (int c = 0; c < hold; c++) begin
            check("hold_m_valid", m_valid, 1);
            check("hold_m_data", m_data, exp_q[0]);
            check("hold_s_ready", s_ready, 0);
            check("hold_core_start", core_start, 0);
            @(negedge ap_clk);
        end
        collect();
    endtask

    initial begin
        int lat;
        ap_rst = 1'b1; s_data = '0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
        done_en = 1'b1; extra_done = 1'b0; ret_ovr = 1'b0;
        repeat (3) @(negedge ap_clk);
        check("rst_s_ready", s_ready, 1);
        check("rst_core_in1", core_in1, 0);
        check("rst_core_in6", core_in6, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_core_start", core_start, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_busy", busy, 0);
        check("rst_done_cnt", done_cnt, 0);
        ap_rst = 1'b0;
        @(negedge ap_clk);

        // Reset while RUN: result dropped, back to COLLECT
        send_words(32'h100, 6, 1'b1);
        check("pre_rst_busy", busy, 1);
        ap_rst = 1'b1;
        @(negedge ap_clk);
        check("midrst_busy", busy, 0);
        check("midrst_core_start", core_start, 0);
        check("midrst_m_valid", m_valid, 0);
        check("midrst_done_cnt", done_cnt, 0);
        ap_rst = 1'b0;
        repeat (2) @(negedge ap_clk);
        check("post_rst_m_valid", m_valid, 0);

        run_frame(32'd1, 0);
        check("first_result", last_res, 32'hDEADBEEF);

        // Short frame: error pulse, operands already written keep their values
        send_words(32'd7, 3, 1'b1);
        check("short_frame_err", frame_err, 1);
        check("short_core_start", core_start, 0);
        check("short_busy", busy, 0);
        check("short_in3", core_in3, 9);
        check("short_in4", core_in4, 4);
        @(negedge ap_clk);
        check("short_err_one_cycle", frame_err, 0);
        run_frame(32'h20, 0);

        // Six words without s_last: dropped with error
        send_words(32'h40, 6, 1'b0);
        check("long_frame_err", frame_err, 1);
        check("long_busy", busy, 0);
        @(negedge ap_clk);
        check("long_err_one_cycle", frame_err, 0);

        run_frame(32'h1000, 10);

        // Done outside RUN is ignored
        extra_done = 1'b1; ret_ovr = 1'b1;
        @(negedge ap_clk);
        extra_done = 1'b0; ret_ovr = 1'b0;
        check("stray_done_m_data", m_data, last_res);
        check("stray_done_m_valid", m_valid, 0);
        check("stray_done_busy", busy, 0);

        while (exp_cnt % (1 << CNT_W) != (1 << CNT_W) - 1) run_frame(32'(exp_cnt * 37), 0);
        run_frame(32'h7777, 0);
        check("done_cnt_wrap", done_cnt, 0);

`ifdef PARKER_FEEDER_TIMEOUT_EN
        done_en = 1'b0;
        send_words(32'h300, 6, 1'b1);
        exp_q.push_back(32'h0);
        wait_valid(lat);
        check("timeout_latency", 32'(lat), TIMEOUT_CYC);
        check("timeout_frame_err", frame_err, 1);
        check("timeout_core_start", core_start, 0);
        collect();
        done_en = 1'b1;
`endif

        run_frame(32'h5A5A0000, 0);
        check("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
